// File: rtl/div_pkg.sv
// Shared types and width constant for the sequential restoring divider.
package div_pkg;

   localparam int DIV_N = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in one dividend bit, trial-subtract, keep or restore.
// Purely combinational, no handshake; reused by div_unit on every CALC cycle.
module div_step
   import div_pkg::*;
#(
   parameter int N = DIV_N
)
(
   input  logic [N-1:0] i_r,
   input  logic         i_bit,
   input  logic [N-1:0] i_divisor,
   output logic [N-1:0] o_r,
   output logic         o_q
);

   logic [N:0] w_s;
   logic [N:0] w_t;

   assign w_s = {i_r, i_bit};
   assign w_t = w_s - {1'b0, i_divisor};

   // A set borrow bit means S < divisor, so restore S; either way the result is below the divisor.
   assign o_q = ~w_t[N];
   assign o_r = w_t[N] ? w_s[N-1:0] : w_t[N-1:0];

endmodule

// File: rtl/div_unit.sv
// 2N/N unsigned restoring divider, one quotient bit per clock; N cycles normal, result right after accept on error.
// Valid/ready on both sides: in_ready only in IDLE, result held in DONE until out_ready.
module div_unit
   import div_pkg::*;
#(
   parameter int N = DIV_N
)
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*N-1:0] dividend,
   input  logic [N-1:0]   divisor,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N-1:0]   quotient,
   output logic [N-1:0]   remainder,
   output logic           div_by_zero,
   output logic           overflow
);

   localparam int CW = $clog2(N) + 1;

   div_state_t   r_state;
   div_state_t   w_state_nxt;

   // Partial remainder always stays below the divisor after a step, so N bits hold it.
   logic [N-1:0]  r_rem;
   logic [N-1:0]  r_q;
   logic [N-1:0]  r_div;
   logic [CW-1:0] r_cnt;
   logic [N-1:0]  r_quotient;
   logic [N-1:0]  r_remainder;
   logic          r_dbz;
   logic          r_ovf;

   logic [N-1:0]  w_div_hi;
   logic          w_last;
   logic          w_qbit;
   logic [N-1:0]  w_rem_nxt;

   assign w_div_hi = dividend[2*N-1:N];
   assign w_last   = (r_cnt == CW'(N-1));

   div_step #(.N(N)) u_step (
      .i_r       (r_rem),
      .i_bit     (r_q[N-1]),
      .i_divisor (r_div),
      .o_r       (w_rem_nxt),
      .o_q       (w_qbit)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (in_valid) begin
               if ((divisor == '0) || (w_div_hi >= divisor)) w_state_nxt = DONE;
               else                                          w_state_nxt = CALC;
            end
         end
         CALC:    if (w_last)    w_state_nxt = DONE;
         DONE:    if (out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rem       <= '0;
         r_q         <= '0;
         r_div       <= '0;
         r_cnt       <= '0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_dbz       <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_dbz <= 1'b0;
                  r_ovf <= 1'b0;
                  if (divisor == '0) begin
                     r_quotient  <= '1;
                     r_remainder <= dividend[N-1:0];
                     r_dbz       <= 1'b1;
                  end else if (w_div_hi >= divisor) begin
                     r_quotient  <= '1;
                     r_remainder <= '0;
                     r_ovf       <= 1'b1;
                  end else begin
                     r_rem <= w_div_hi;
                     r_q   <= dividend[N-1:0];
                     r_div <= divisor;
                     r_cnt <= '0;
                  end
               end
            end
            CALC: begin
               r_rem <= w_rem_nxt;
               r_q   <= {r_q[N-2:0], w_qbit};
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  r_quotient  <= {r_q[N-2:0], w_qbit};
                  r_remainder <= w_rem_nxt;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready    = (r_state == IDLE);
   assign out_valid   = (r_state == DONE);
   assign quotient    = r_quotient;
   assign remainder   = r_remainder;
   assign div_by_zero = r_dbz;
   assign overflow    = r_ovf;

endmodule

// File: tb/tb_div_unit.sv
// Directed and constructed-random checks of div_unit at N=16.
module tb_div_unit;

   localparam int N = 16;

   logic           clk;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [2*N-1:0] dividend;
   logic [N-1:0]   divisor;
   logic           out_valid;
   logic           out_ready;
   logic [N-1:0]   quotient;
   logic [N-1:0]   remainder;
   logic           div_by_zero;
   logic           overflow;

   int checks   = 0;
   int failures = 0;

   div_unit #(.N(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one operation in IDLE, returns edges after the accept edge until out_valid.
   task automatic do_op(input logic [31:0] dd, input logic [15:0] dv, output int lat);
      in_valid = 1'b1;
      dividend = dd;
      divisor  = dv;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      int lat;
      logic [15:0] hq, hr;
      bit ok;
      logic [31:0] a, b, r;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      dividend = '0; divisor = '0;
      repeat (3) tick();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_q_r", {quotient, remainder}, 32'h0);
      chk("rst_flags", {div_by_zero, overflow}, 0);
      @(negedge clk); rst_n = 1'b1;
      tick();

      // 100 / 7
      do_op(32'd100, 16'd7, lat);
      chk("d100_lat", lat, 16);
      chk("d100_q_r", {quotient, remainder}, {16'd14, 16'd2});
      chk("d100_flags", {div_by_zero, overflow}, 0);
      chk("d100_in_ready", in_ready, 0);
      release_result();
      chk("d100_idle", {in_ready, out_valid}, 2'b10);

      // FFFF / 1 fits exactly
      do_op(32'h0000_FFFF, 16'h0001, lat);
      chk("ffff_lat", lat, 16);
      chk("ffff_q_r", {quotient, remainder}, 32'hFFFF_0000);
      chk("ffff_flags", {div_by_zero, overflow}, 0);
      release_result();

      // 10000 / 1 overflows
      do_op(32'h0001_0000, 16'h0001, lat);
      chk("ovf_lat", lat, 0);
      chk("ovf_q_r", {quotient, remainder}, 32'hFFFF_0000);
      chk("ovf_flags", {div_by_zero, overflow}, 2'b01);
      release_result();

      // divide by zero
      do_op(32'h1234_5678, 16'h0000, lat);
      chk("dbz_lat", lat, 0);
      chk("dbz_q_r", {quotient, remainder}, 32'hFFFF_5678);
      chk("dbz_flags", {div_by_zero, overflow}, 2'b10);
      release_result();

      // 10 / 3 with out_ready already high: result visible for one cycle
      out_ready = 1'b1;
      do_op(32'd10, 16'd3, lat);
      chk("d10_lat", lat, 16);
      chk("d10_q_r", {quotient, remainder}, {16'd3, 16'd1});
      chk("d10_flags", {div_by_zero, overflow}, 0);
      tick();
      chk("d10_one_cycle", {in_ready, out_valid}, 2'b10);
      out_ready = 1'b0;

      // 1000 / 9 = 111 r 1 with in_valid/dividend noise during CALC and DONE
      in_valid = 1'b1; dividend = 32'd1000; divisor = 16'd9;
      tick();
      ok = 1'b1; lat = 0;
      while (!out_valid && lat < 40) begin
         in_valid = ~in_valid;
         dividend = $urandom;
         divisor  = 16'd0;
         if (in_ready !== 1'b0) ok = 1'b0;
         tick();
         lat++;
      end
      chk("hold_calc_lat", lat, 16);
      chk("hold_calc_in_ready", ok, 1);
      hq = quotient; hr = remainder;
      chk("hold_q_r", {hq, hr}, {16'd111, 16'd1});
      for (int i = 0; i < 5; i++) begin
         in_valid = ~in_valid;
         dividend = $urandom;
         tick();
         chk("hold_done_stable", {out_valid, in_ready, quotient, remainder, div_by_zero, overflow},
             {2'b10, 16'd111, 16'd1, 2'b00});
      end
      in_valid = 1'b0;
      release_result();
      chk("hold_released", {in_ready, out_valid}, 2'b10);
      tick();
      chk("hold_no_accept", {in_ready, out_valid}, 2'b10);

      // reset at CALC count 8
      in_valid = 1'b1; dividend = 32'd100; divisor = 16'd7;
      tick();
      in_valid = 1'b0;
      repeat (8) tick();
      chk("abort_in_calc", {in_ready, out_valid}, 2'b00);
      rst_n = 1'b0;
      #1;
      chk("abort_ready_valid", {in_ready, out_valid}, 2'b10);
      chk("abort_q_r", {quotient, remainder}, 32'h0);
      chk("abort_flags", {div_by_zero, overflow}, 0);
      @(negedge clk); rst_n = 1'b1;
      tick();
      do_op(32'd100, 16'd7, lat);
      chk("after_rst_lat", lat, 16);
      chk("after_rst_q_r", {quotient, remainder}, {16'd14, 16'd2});
      release_result();

      // constructed random: dividend = A*B + r, r < B
      for (int k = 0; k < 1000; k++) begin
         a = $urandom_range(0, 65535);
         b = $urandom_range(1, 65535);
         r = $urandom_range(0, b - 1);
         do_op(a * b + r, b[15:0], lat);
         chk("rand_q_r", {quotient, remainder}, {a[15:0], r[15:0]});
         chk("rand_flags_lat", {div_by_zero, overflow, 6'(lat)}, {2'b00, 6'd16});
         release_result();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
